uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmitter. It serialises one word per `tx_valid`/`tx_ready` handshake into an asynchronous frame with a configurable number of data bits, optional parity, and 1 or 2 stop bits. The bit period is a run-time divisor that is latched per frame. It uses a single clock domain with an internal baud-enable counter and generates no derived clock. It sits between a byte producer (FIFO or command logic) and the board TX pin, as the drop-in successor of the fixed 8N1 transmitter.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal 5..9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal values are 1 or 2.
- `DIV_W`, default 16: width of the baud divisor input.
- `clk` input, 1 bit: system clock; all logic on its rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `baud_div` input, `DIV_W` bits: clocks per bit, sampled at accept; a value of 0 is treated as 1.
- `tx_valid` input, 1 bit: the producer has a word on `tx_data`.
- `tx_data` input, `DATA_BITS` bits: word to send, LSB first.
- `tx_ready` output, 1 bit: the block can accept a word this cycle.
- `tx_busy` output, 1 bit: a frame is on the line.
- `tx` output, 1 bit: serial line, idles high.

## Operation
- **Frame length.** N = 1 + `DATA_BITS` + (`PARITY`≠0) + `STOP_BITS` bits.
  - Order on the line: start (0), d[0]..d[DATA_BITS-1], parity (if enabled), then stop bit(s) (1).
- **Parity.**
  - Odd: the parity bit makes the total count of 1s in data + parity odd (the bit is ~^data).
  - Even: the parity bit is ^data.
- **States.**
  - IDLE → START → DATA → (PARITY) → STOP → IDLE.
  - From STOP the block can also go directly back to START on a back-to-back accept.
- **Accept.** An accept is the edge where `tx_valid && tx_ready`. At that edge the block:
  - latches `tx_data` into the shift register;
  - latches `baud_div` (0 becomes 1) into the divisor register;
  - computes parity from the latched data;
  - sets `tx` to 0 and enters START with the bit counter cleared.
- **Bit timing.**
  - Each bit is held for exactly D = latched divisor clock cycles, counted by a down-counter.
  - On counter expiry the block advances to the next bit or state.
  - DATA counts `DATA_BITS` bits; STOP counts `STOP_BITS` bits.
- **Ready and busy.**
  - `tx_ready` = 1 in IDLE, and also during the final clock cycle of the last stop bit. It is 0 otherwise.
  - `tx_busy` = 1 from the accept edge until the block returns to IDLE, or until the next frame's start if back-to-back.
- **Back-to-back.** An accept in the final stop cycle begins the next start bit on the following cycle, with zero idle gap. Otherwise the block goes to IDLE with `tx` = 1.
- **Stable input.** Changes to `tx_data`, `baud_div` or `tx_valid` while `tx_ready` = 0 have no effect on the frame in flight.
- **Reset.** Reset outputs are `tx` = 1, `tx_ready` = 1, `tx_busy` = 0, state IDLE, counters 0.
  - Reset mid-frame abandons the frame: the line returns high on the edge where `rst` is sampled.
  - No accept occurs in a cycle where `rst` = 1.
- **Arithmetic.**
  - The baud counter is `DIV_W` bits wide and the bit counter is ⌈log2(max(DATA_BITS,2))⌉+1 bits wide.
  - No wrap-around is possible within a frame.

## Timing
- All outputs are registered.
- Accept at edge E0: `tx` = 0 and `tx_ready` = 0 are visible in the cycle after E0.
- Bit k (0 = start) occupies the cycles after edges E0 + k·D through E0 + (k+1)·D.
- `tx_ready` rises after edge E0 + N·D − 1.
- With no new accept:
  - `tx_busy` falls after edge E0 + N·D;
  - IDLE is reached at that same edge.
- Throughput: one frame per N·D cycles when back-to-back. The frame-to-frame period is exactly N·D.
- With D = 1, `tx_ready` is high every cycle of the single stop bit. Continuous streaming works at one bit per clock.

## Test plan
- **Reset values:** defaults, `baud_div` = 4, `rst` held 3 cycles → `tx` = 1, `tx_ready` = 1, `tx_busy` = 0 throughout and after release.
- **Single 8N1 frame:** send 0xA5 with `baud_div` = 4 → line reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. `tx_ready` low for 39 cycles and high again after edge E0+39.
- **8E2 and 7O1 parity frames:**
  - `PARITY`=2, `STOP_BITS`=2, data 0x03 → parity bit 0, frame 12 bits, 4 cycles each.
  - `DATA_BITS`=7, `PARITY`=1, data 0x7F → parity bit 0. Data 0x7E → parity bit 1.
- **Back-to-back:** `tx_valid` held high with 0x55 then 0x0F, `baud_div` = 2 → second start bit begins immediately after the first stop bit, no gap. Accepts are exactly 20 cycles apart.
- **Divisor latching:** change `baud_div` from 4 to 8 mid-frame → current frame keeps 4 cycles per bit. The next accepted frame uses 8. `baud_div` = 0 gives 1 cycle per bit.
- **Reset mid-frame:** assert `rst` during data bit 3 → `tx` = 1, `tx_ready` = 1, `tx_busy` = 0 at the next edge. A following 0x81 frame is transmitted correctly with no residue.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmitter: one word per valid/ready handshake, configurable data bits,
// parity and stop bits, with a per-frame latched bit-period divisor.
module uart_tx_frame #(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int DIV_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DIV_W-1:0]     baud_div,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 tx_busy,
   output logic                 tx
);

   localparam int BW = $clog2((DATA_BITS < 2) ? 2 : DATA_BITS) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [DIV_W-1:0]     cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;

   logic                 accept;
   logic                 expire;
   logic [DIV_W-1:0]     div_in;

   assign accept = tx_valid && ready_q;
   assign expire = (cnt_q == '0);
   assign div_in = (baud_div == '0) ? DIV_W'(1) : baud_div;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      par_d   = par_q;
      tx_d    = tx_q;

      if (!expire) begin
         cnt_d = cnt_q - DIV_W'(1);
      end else if (state_q != S_IDLE) begin
         cnt_d = div_q - DIV_W'(1);
      end

      case (state_q)
         S_START: begin
            if (expire) begin
               state_d = S_DATA;
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               bit_d   = '0;
            end
         end
         S_DATA: begin
            if (expire) begin
               if (bit_q == BW'(DATA_BITS - 1)) begin
                  bit_d = '0;
                  if (PARITY != 0) begin
                     state_d = S_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + BW'(1);
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end
         end
         S_PARITY: begin
            if (expire) begin
               state_d = S_STOP;
               tx_d    = 1'b1;
               bit_d   = '0;
            end
         end
         S_STOP: begin
            if (expire) begin
               tx_d = 1'b1;
               if (bit_q == BW'(STOP_BITS - 1)) begin
                  state_d = S_IDLE;
                  bit_d   = '0;
                  cnt_d   = '0;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         default: begin
            tx_d = 1'b1;
         end
      endcase

      // An accept can only land in IDLE or the last stop cycle, so it overrides both.
      if (accept) begin
         state_d = S_START;
         tx_d    = 1'b0;
         shift_d = tx_data;
         div_d   = div_in;
         cnt_d   = div_in - DIV_W'(1);
         bit_d   = '0;
         par_d   = (PARITY == 1) ? ~^tx_data : ^tx_data;
      end

      busy_d  = (state_d != S_IDLE);
      ready_d = (state_d == S_IDLE) ||
                ((state_d == S_STOP) && (bit_d == BW'(STOP_BITS - 1)) && (cnt_d == '0));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         div_q   <= '0;
         cnt_q   <= '0;
         bit_q   <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   assign tx       = tx_q;
   assign tx_ready = ready_q;
   assign tx_busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: 8N1, 8E2 and 7O1 instances driven from a
// table of hand-computed frames plus reset sequences.
module tb_uart_tx_frame;

   logic        clk;
   logic        rst;
   logic [15:0] baud_div;
   logic [7:0]  tx_data;
   logic [2:0]  vld;
   logic [2:0]  txs;
   logic [2:0]  rdy;
   logic [2:0]  busy;

   int tests = 0;
   int fails = 0;

   // Expected stream: bit k of exp is line bit k (bit 0 = first start bit).
   typedef struct {
      int          inst;
      logic [7:0]  data;
      logic [7:0]  data2;
      int          div;
      int          div_mid;
      int          nfr;
      int          nbits;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[9];

   uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_W(16)) u0 (
      .clk(clk), .rst(rst), .baud_div(baud_div), .tx_valid(vld[0]),
      .tx_data(tx_data), .tx_ready(rdy[0]), .tx_busy(busy[0]), .tx(txs[0]));

   uart_tx_frame #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .DIV_W(16)) u1 (
      .clk(clk), .rst(rst), .baud_div(baud_div), .tx_valid(vld[1]),
      .tx_data(tx_data), .tx_ready(rdy[1]), .tx_busy(busy[1]), .tx(txs[1]));

   uart_tx_frame #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .DIV_W(16)) u2 (
      .clk(clk), .rst(rst), .baud_div(baud_div), .tx_valid(vld[2]),
      .tx_data(tx_data[6:0]), .tx_ready(rdy[2]), .tx_busy(busy[2]), .tx(txs[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_idle(input string tag, input int inst);
      chk($sformatf("%s tx", tag), txs[inst], 1'b1);
      chk($sformatf("%s ready", tag), rdy[inst], 1'b1);
      chk($sformatf("%s busy", tag), busy[inst], 1'b0);
   endtask

   // Returns 1 once the instance shows ready at a negedge; the next posedge accepts.
   task automatic wait_ready(input int inst, input string tag, output bit ok);
      int n;
      n = 0;
      while (!rdy[inst] && n < 100) begin
         @(negedge clk);
         n++;
      end
      ok = rdy[inst];
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s accept timeout: ready=%b required 1", tag, rdy[inst]);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int    d;
      int    fl;
      int    tot;
      int    k;
      bit    ok;
      string tag;
      tag = $sformatf("vec%0d", idx);
      d   = (v.div == 0) ? 1 : v.div;
      fl  = (v.nbits / v.nfr) * d;
      tot = v.nbits * d;
      @(negedge clk);
      tx_data      = v.data;
      baud_div     = v.div[15:0];
      vld[v.inst]  = 1'b1;
      wait_ready(v.inst, tag, ok);
      if (!ok) begin
         vld[v.inst] = 1'b0;
         return;
      end
      @(negedge clk);
      for (int c = 0; c < tot; c++) begin
         k = c / d;
         chk($sformatf("%s tx c=%0d", tag, c), txs[v.inst], v.exp[k]);
         chk($sformatf("%s ready c=%0d", tag, c), rdy[v.inst], (c % fl) == (fl - 1));
         chk($sformatf("%s busy c=%0d", tag, c), busy[v.inst], 1'b1);
         if (v.nfr == 1) begin
            if (c == 0) vld[v.inst] = 1'b0;
            if (c == 5) begin
               tx_data     = ~v.data;
               baud_div    = v.div_mid[15:0];
               vld[v.inst] = 1'b1;
            end
            if (c == 6) vld[v.inst] = 1'b0;
         end else begin
            if (c == 0)  tx_data = v.data2;
            if (c == fl) vld[v.inst] = 1'b0;
         end
         @(negedge clk);
      end
      chk_idle($sformatf("%s end", tag), v.inst);
      $display("[TB] %s inst=%0d data=%h div=%0d frames=%0d checked", tag, v.inst, v.data, v.div, v.nfr);
   endtask

   initial begin
      bit ok;
      //           inst data   data2  div mid nfr nbits exp
      vecs[0] = '{0, 8'hA5, 8'h00, 4, 4, 1, 10, 32'h0000_034A};
      vecs[1] = '{1, 8'h03, 8'h00, 4, 4, 1, 12, 32'h0000_0C06};
      vecs[2] = '{2, 8'h7F, 8'h00, 4, 4, 1, 10, 32'h0000_02FE};
      vecs[3] = '{2, 8'h7E, 8'h00, 3, 3, 1, 10, 32'h0000_03FC};
      vecs[4] = '{0, 8'h55, 8'h0F, 2, 2, 2, 20, 32'h0008_7AAA};
      vecs[5] = '{0, 8'hA5, 8'h00, 4, 8, 1, 10, 32'h0000_034A};
      vecs[6] = '{0, 8'h3C, 8'h00, 8, 8, 1, 10, 32'h0000_0278};
      vecs[7] = '{0, 8'hA5, 8'h00, 0, 0, 1, 10, 32'h0000_034A};
      vecs[8] = '{0, 8'h81, 8'h00, 4, 4, 1, 10, 32'h0000_0302};

      rst      = 1'b1;
      baud_div = 16'd4;
      tx_data  = 8'h00;
      vld      = 3'b000;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) chk_idle($sformatf("reset c=%0d u%0d", c, i), i);
      end
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk_idle($sformatf("post-reset u%0d", i), i);
      $display("[TB] reset values checked");

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Abandon a frame during data bit 3 (line bit 4), then send a clean frame.
      @(negedge clk);
      tx_data  = 8'h81;
      baud_div = 16'd4;
      vld[0]   = 1'b1;
      wait_ready(0, "midreset", ok);
      if (ok) begin
         @(negedge clk);
         vld[0] = 1'b0;
         repeat (17) @(negedge clk);
         chk("midreset pre tx", txs[0], 1'b0);
         chk("midreset pre busy", busy[0], 1'b1);
         rst = 1'b1;
         @(negedge clk);
         chk_idle("midreset", 0);
         rst = 1'b0;
         @(negedge clk);
         chk_idle("midreset release", 0);
      end
      vld[0] = 1'b0;
      rst    = 1'b0;
      $display("[TB] mid-frame reset checked");
      run_vec(vecs[8], 8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
